// File: rtl/xyz_pkg.sv
// Shared types and helpers for the xyz three-wire serial link.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: TX state enum, frame counter width, gap timer width, odd parity helper.
package xyz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } xyz_tx_state_e;

  localparam int XYZ_CNT_W = 16;
  localparam int XYZ_GAP_W = 4;

  // Odd parity over up to 32 bits; zero-extended inputs do not change the result.
  function automatic logic xyz_odd_parity(input logic [31:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/xyz_gap_timer.sv
// Load / count-down timer that times inter-frame idle gaps.
// Latency: done reflects the count register, so it updates one cycle after load.
// Backpressure: none; counts every cycle once loaded.
// Ports: clk, rst_n, load (take load_val this edge), load_val[3:0], done (count <= 1).
module xyz_gap_timer
  import xyz_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [XYZ_GAP_W-1:0] load_val,
  output logic                 done
);

  logic [XYZ_GAP_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // A load of N gives N cycles in the waiting state: the cycle showing 1 is the last.
  assign done = (cnt_q <= XYZ_GAP_W'(1));

endmodule

// File: rtl/xyz_serial_tx.sv
// LSB-first serial transmitter driving the three-wire I link (x frame, y ready, z data).
// Latency: first bit on z one cycle after the accept edge; each bit held until y=1.
// Backpressure: in_ready only in IDLE; receiver stalls any bit by holding y low.
// Ports: clk, rst_n, in_valid/in_ready/in_data[DATA_W], ifc_I_x/ifc_I_y/ifc_I_z,
//        busy (not IDLE), frames_sent[16] (wrapping completed-frame count).
// Build option: define XYZ_TX_PARITY_EN to append an odd parity bit after the data bits.
module xyz_serial_tx
  import xyz_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 ifc_I_x,
  input  logic                 ifc_I_y,
  output logic                 ifc_I_z,
  output logic                 busy,
  output logic [XYZ_CNT_W-1:0] frames_sent
);

`ifdef XYZ_TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int                   BCNT_W   = $clog2(DATA_W + 2);
  localparam logic [BCNT_W-1:0]    LAST_BIT = BCNT_W'(NBITS - 1);
  localparam logic [XYZ_GAP_W-1:0] GAP_LD   = XYZ_GAP_W'(GAP);

  xyz_tx_state_e        state_q, state_d;
  logic [NBITS-1:0]     shift_q;
  logic [NBITS-1:0]     load_word;
  logic [BCNT_W-1:0]    bit_cnt_q;
  logic [XYZ_CNT_W-1:0] frames_sent_q;
  logic                 rst_done_q;
  logic                 accept;
  logic                 consume;
  logic                 last_bit;
  logic                 gap_done;

`ifdef XYZ_TX_PARITY_EN
  assign load_word = {xyz_odd_parity(32'(in_data)), in_data};
`else
  assign load_word = in_data;
`endif

  // rst_done_q keeps in_ready low until the first edge after reset release.
  assign accept   = (state_q == ST_IDLE) && rst_done_q && in_valid;
  assign consume  = (state_q == ST_SHIFT) && ifc_I_y;
  assign last_bit = consume && (bit_cnt_q == LAST_BIT);

  xyz_gap_timer u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (last_bit),
    .load_val (GAP_LD),
    .done     (gap_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus outputs; outputs decode state/registers only, never y or in_valid.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    ifc_I_x  = 1'b0;
    ifc_I_z  = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = rst_done_q;
        busy     = 1'b0;
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        ifc_I_x = 1'b1;
        ifc_I_z = shift_q[0];
        if (last_bit) state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_done) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      frames_sent_q <= '0;
      rst_done_q    <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      if (accept) begin
        shift_q   <= load_word;
        bit_cnt_q <= '0;
      end else if (consume) begin
        shift_q   <= shift_q >> 1;
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (last_bit) frames_sent_q <= frames_sent_q + 1'b1;
    end
  end

  assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_xyz_serial_tx.sv
// Bench for xyz_serial_tx: two instances (GAP=1 and GAP=0) with a frame-level scoreboard.
// Latency: n/a.
// Backpressure: receiver ready driven randomly or with directed stall windows.
module tb_xyz_serial_tx;

  localparam int DW = 8;
`ifdef XYZ_TX_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vld [2] = '{1'b0, 1'b0};
  logic [DW-1:0] dat [2] = '{8'h00, 8'h00};
  logic          yy  [2] = '{1'b1, 1'b1};
  logic          rdy [2];
  logic          x   [2];
  logic          z   [2];
  logic          busy[2];
  logic [15:0]   fs  [2];

  always #5 clk = ~clk;

  xyz_serial_tx #(.DATA_W(DW), .GAP(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]), .in_data(dat[0]),
    .ifc_I_x(x[0]), .ifc_I_y(yy[0]), .ifc_I_z(z[0]), .busy(busy[0]), .frames_sent(fs[0]));

  xyz_serial_tx #(.DATA_W(DW), .GAP(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]), .in_data(dat[1]),
    .ifc_I_x(x[1]), .ifc_I_y(yy[1]), .ifc_I_z(z[1]), .busy(busy[1]), .frames_sent(fs[1]));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  // Frame as it must appear on z: data LSB first, then odd parity when enabled.
  function automatic logic [31:0] exp_vec(input logic [DW-1:0] d);
    logic [31:0] v;
    v = 32'(d);
`ifdef XYZ_TX_PARITY_EN
    v[DW] = ~(^d);
`endif
    return v;
  endfunction

  // Receiver-ready driver: directed stall window [sf, st) wins over random mode.
  int   cyc = 0;
  int   sf [2] = '{0, 0};
  int   st [2] = '{0, 0};
  logic rnd_y = 1'b0;

  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (cyc >= sf[k] && cyc < st[k]) yy[k] = 1'b0;
      else if (rnd_y)                  yy[k] = ($urandom_range(0, 3) != 0);
      else                             yy[k] = 1'b1;
    end
  end

  // Scoreboard / protocol monitor, sampled on the falling edge.
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic          post_act [2] = '{1'b0, 1'b0};
  int            post_n   [2] = '{0, 0};
  logic          first_pend[2] = '{1'b0, 1'b0};
  logic          first_bit[2] = '{1'b0, 1'b0};
  int            flen     [2] = '{0, 0};
  int            stl      [2] = '{0, 0};
  int            nb       [2] = '{0, 0};
  logic [31:0]   rxv      [2] = '{32'h0, 32'h0};
  logic [31:0]   last_rx  [2] = '{32'h0, 32'h0};
  int            last_len [2] = '{0, 0};
  logic [15:0]   done_cnt [2] = '{16'h0, 16'h0};
  logic [15:0]   fs_base  [2] = '{16'h0, 16'h0};
  logic          have_prev[2] = '{1'b0, 1'b0};
  int            prev_acc [2] = '{0, 0};
  logic [DW-1:0] mon_d;
  int            mon_qs;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        if (k == 0) exp_q0.delete(); else exp_q1.delete();
        post_act[k] = 1'b0; first_pend[k] = 1'b0; flen[k] = 0; stl[k] = 0;
        nb[k] = 0; rxv[k] = '0; done_cnt[k] = '0; have_prev[k] = 1'b0;
      end else begin
        if (post_act[k]) begin
          if (post_n[k] == 0) check("frames_sent", 32'(fs[k]), 32'(16'(fs_base[k] + done_cnt[k])));
          if (post_n[k] < gap_of(k)) begin
            check("gap_state", {x[k], rdy[k], busy[k]}, 3'b001);
          end else begin
            check("ready_after", {x[k], rdy[k], busy[k]}, 3'b010);
            post_act[k] = 1'b0;
          end
          post_n[k]++;
        end
        if (first_pend[k]) begin
          check("first_bit_latency", {x[k], z[k]}, {1'b1, first_bit[k]});
          first_pend[k] = 1'b0;
        end
        if (x[k]) begin
          check("rdy_low_in_shift", rdy[k], 1'b0);
          flen[k]++;
          if (yy[k]) begin
            rxv[k][nb[k]] = z[k];
            nb[k]++;
          end else begin
            stl[k]++;
          end
          if (nb[k] == NB) begin
            mon_qs = (k == 0) ? exp_q0.size() : exp_q1.size();
            check("frame_expected", mon_qs != 0, 1'b1);
            if (mon_qs != 0) begin
              mon_d = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check("frame_data", rxv[k], exp_vec(mon_d));
            end
            check("frame_len", flen[k], NB + stl[k]);
            last_rx[k] = rxv[k]; last_len[k] = flen[k];
            done_cnt[k] = done_cnt[k] + 16'd1;
            flen[k] = 0; stl[k] = 0; nb[k] = 0; rxv[k] = '0;
            post_act[k] = 1'b1; post_n[k] = 0;
          end
        end
        if (vld[k] && rdy[k]) begin
          if (k == 0) exp_q0.push_back(dat[k]); else exp_q1.push_back(dat[k]);
          first_pend[k] = 1'b1; first_bit[k] = dat[k][0];
          if (have_prev[k]) check("accept_spacing", (cyc - prev_acc[k]) >= NB + gap_of(k) + 1, 1'b1);
          have_prev[k] = 1'b1; prev_acc[k] = cyc;
        end
      end
    end
  end

  int acc_cyc[2] = '{0, 0};

  // Offer a word, wait (bounded) for acceptance, optionally stall y for nstall cycles after it.
  task automatic send(input int k, input logic [DW-1:0] d, input int nstall, input bit hold);
    int n;
    @(posedge clk); #1;
    vld[k] = 1'b1; dat[k] = d;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (rdy[k]) break;
      n++;
    end
    if (n >= 500) check("send_timeout", rdy[k], 1'b1);
    sf[k] = cyc + 1; st[k] = cyc + 1 + nstall;
    acc_cyc[k] = cyc + 1;
    @(posedge clk); #1;
    if (!hold) begin
      vld[k] = 1'b0;
      dat[k] = DW'($urandom);
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (n < 500) begin
      @(negedge clk);
      if (!busy[k] && !post_act[k]) break;
      n++;
    end
    if (n >= 500) check("idle_timeout", busy[k], 1'b0);
    #1;
  endtask

  int a1;

  initial begin
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_rdy", rdy[k], 1'b0);
      check("rst_xz", {x[k], z[k], busy[k]}, 3'b000);
      check("rst_fs", 32'(fs[k]), 32'h0);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) check("rdy_after_reset", rdy[k], 1'b1);

    // 0xA5, y held high, GAP=1
    send(0, 8'hA5, 0, 1'b0);
    wait_idle(0);
    check("a5_bits", last_rx[0], exp_vec(8'hA5));
    check("a5_len", last_len[0], NB);
    check("a5_fs", 32'(fs[0]), 32'd1);

    // bit 0 stalled for 3 cycles
    send(0, 8'h01, 3, 1'b0);
    wait_idle(0);
    check("stall_bits", last_rx[0], exp_vec(8'h01));
    check("stall_len", last_len[0], NB + 3);

`ifdef XYZ_TX_PARITY_EN
    send(0, 8'h03, 0, 1'b0);
    wait_idle(0);
    check("par_03", last_rx[0][DW], 1'b1);
    send(0, 8'h07, 0, 1'b0);
    wait_idle(0);
    check("par_07", last_rx[0][DW], 1'b0);
`endif

    // back-to-back with in_valid held
    for (int k = 0; k < 2; k++) begin
      send(k, 8'h0F, 0, 1'b1);
      a1 = acc_cyc[k];
      send(k, 8'hF0, 0, 1'b0);
      check("b2b_spacing", acc_cyc[k] - a1, NB + gap_of(k) + 1);
      wait_idle(k);
      check("b2b_second", last_rx[k], exp_vec(8'hF0));
    end

    // reset while bit 4 of 0xFF is on the wire
    send(0, 8'hFF, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("pre_reset_x", x[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_xz", {x[0], z[0], busy[0]}, 3'b000);
    check("midrst_rdy", rdy[0], 1'b0);
    check("midrst_fs0", 32'(fs[0]), 32'h0);
    check("midrst_fs1", 32'(fs[1]), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_rdy", rdy[0], 1'b1);
    check("post_rst_fs", 32'(fs[0]), 32'h0);
    send(0, 8'h3C, 0, 1'b0);
    wait_idle(0);
    check("post_rst_frame", last_rx[0], exp_vec(8'h3C));
    check("post_rst_fs1", 32'(fs[0]), 32'd1);

    // randomized traffic with random receiver stalls
    rnd_y = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 25; i++) begin
        send(k, DW'($urandom), $urandom_range(0, 2), 1'b0);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      wait_idle(k);
    end
    rnd_y = 1'b0;
    check("drain0", exp_q0.size(), 0);
    check("drain1", exp_q1.size(), 0);

    // counter wrap: preload 0xFFFF, one more frame
    wait_idle(1);
    u_dut1.frames_sent_q = 16'hFFFF;
    fs_base[1] = 16'hFFFF - done_cnt[1];
    send(1, 8'h5A, 0, 1'b0);
    wait_idle(1);
    check("wrap", 32'(fs[1]), 32'h0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
